img_frame_sequencer: RTL and testbench

- Sequences frame-processing jobs through the image reader/processing datapath (dual-pixel RGB888 reader with brightness, invert and threshold modes).
- Accepts operation commands from a host through a valid/ready interface and buffers them in a 4-entry FIFO.
- For each job it latches the datapath configuration, launches the reader with a reset-release pulse, and tracks HSYNC lines and ctrl_done.
- Reports per-frame completion and error status, with a watchdog against stalled frames.

---
 rtl/img_pkg.sv | 41 ++++
 rtl/img_cmd_fifo.sv | 55 +++++
 rtl/img_frame_sequencer.sv | 161 ++++++++++++++++
 tb/tb_img_frame_sequencer.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared definitions for the image frame sequencer: op and error encodings,
// FSM states and the packed command word carried through the command FIFO.
package img_pkg;

    localparam logic [1:0] OP_PASS     = 2'd0;
    localparam logic [1:0] OP_BRIGHT   = 2'd1;
    localparam logic [1:0] OP_INVERT   = 2'd2;
    localparam logic [1:0] OP_THRESH   = 2'd3;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_LINES   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_ABORT   = 2'd3;

    localparam int CMD_W = 11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_RUN    = 3'd3,
        ST_REPORT = 3'd4
    } state_t;

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] value;
        logic       sign;
    } cmd_t;

    function automatic cmd_t pack_cmd(input logic [1:0] op,
                                      input logic [7:0] value,
                                      input logic       sign);
        cmd_t c;
        c.op    = op;
        c.value = value;
        c.sign  = sign;
        return c;
    endfunction

endpackage

// File: rtl/img_cmd_fifo.sv
// Small synchronous command FIFO; head entry is always visible on rd_data.
// Writes when full and reads when empty are dropped.
module img_cmd_fifo
    import img_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic             push,
    input  logic             pop,
    input  logic [CMD_W-1:0] wr_data,
    output logic [CMD_W-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [CMD_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             wr_ok;
    logic             rd_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign wr_ok   = push && !full;
    assign rd_ok   = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by natural overflow
    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/img_frame_sequencer.sv
// Frame job sequencer: pops queued commands, holds the datapath config,
// pulses the reader reset, counts HSYNC lines and reports frame status.
//
// state     | meaning
// ----------+-------------------------------------------------------
// ST_IDLE   | reader held in reset, waiting for a queued command
// ST_LOAD   | config latched, line/watchdog counters cleared
// ST_LAUNCH | reader reset held low for RST_PULSE cycles
// ST_RUN    | reader running; count lines, watchdog ticking
// ST_REPORT | one-cycle frame_done with status
module img_frame_sequencer
    import img_pkg::*;
#(
    parameter int          HEIGHT     = 512,
    parameter int          RST_PULSE  = 4,
    parameter logic [23:0] TIMEOUT    = 24'd1000000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_value,
    input  logic       cmd_sign,
    input  logic       abort,
    input  logic       rd_hsync,
    input  logic       rd_vsync,
    input  logic       rd_done,
    output logic       rd_rst_n,
    output logic [1:0] cfg_op,
    output logic [7:0] cfg_value,
    output logic       cfg_sign,
    output logic       busy,
    output logic       frame_done,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic [9:0] line_count
);

    localparam logic [23:0] WDOG_LAST  = 24'(TIMEOUT - 24'd1);
    localparam logic [9:0]  HEIGHT_L   = 10'(HEIGHT);
    localparam logic [3:0]  PULSE_LAST = 4'(RST_PULSE - 1);

    state_t           state;
    state_t           state_n;
    logic [CMD_W-1:0] fifo_wdata;
    logic [CMD_W-1:0] fifo_head;
    cmd_t             head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic [3:0]       pulse_cnt;
    logic [23:0]      wdog;
    logic [1:0]       code_q;
    logic [1:0]       code_n;
    logic             hs_q;
    logic             hs_edge;
    logic [9:0]       lines_next;
    logic             vsync_late;
    logic             unused_dbg;

    assign fifo_wdata = pack_cmd(cmd_op, cmd_value, cmd_sign);
    assign head       = cmd_t'(fifo_head);
    assign cmd_ready  = !fifo_full;

    img_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .HCLK    (HCLK),
        .HRESET  (HRESET),
        .push    (cmd_valid),
        .pop     (pop),
        .wr_data (fifo_wdata),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Sticky debug flag only; kept for probing, not routed to a port.
    assign unused_dbg = vsync_late;

    assign hs_edge    = rd_hsync && !hs_q;
    assign lines_next = (hs_edge && (line_count != 10'h3FF)) ? line_count + 10'd1 : line_count;

    always_comb begin
        state_n = state;
        code_n  = code_q;
        pop     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_n = ST_LOAD;
                end
            end
            ST_LOAD:   state_n = ST_LAUNCH;
            ST_LAUNCH: if (pulse_cnt == 4'd0) state_n = ST_RUN;
            ST_RUN: begin
                // done uses lines_next so an HSYNC edge coincident with done counts
                if (abort) begin
                    state_n = ST_REPORT;
                    code_n  = ERR_ABORT;
                end else if (rd_done) begin
                    state_n = ST_REPORT;
                    code_n  = (lines_next == HEIGHT_L) ? ERR_OK : ERR_LINES;
                end else if (wdog == WDOG_LAST) begin
                    state_n = ST_REPORT;
                    code_n  = ERR_TIMEOUT;
                end
            end
            ST_REPORT: state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end

    assign busy       = (state != ST_IDLE);
    assign frame_done = (state == ST_REPORT);
    assign frame_err  = frame_done && (code_q != ERR_OK);
    assign err_code   = frame_done ? code_q : ERR_OK;

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            state      <= ST_IDLE;
            code_q     <= ERR_OK;
            rd_rst_n   <= 1'b0;
            hs_q       <= 1'b0;
            cfg_op     <= 2'd0;
            cfg_value  <= 8'd0;
            cfg_sign   <= 1'b0;
            pulse_cnt  <= 4'd0;
            wdog       <= 24'd0;
            line_count <= 10'd0;
            vsync_late <= 1'b0;
        end else begin
            state    <= state_n;
            code_q   <= code_n;
            rd_rst_n <= (state_n == ST_RUN);
            hs_q     <= rd_hsync;
            if (pop) begin
                cfg_op    <= head.op;
                cfg_value <= head.value;
                cfg_sign  <= head.sign;
            end
            case (state)
                ST_LOAD: begin
                    pulse_cnt  <= PULSE_LAST;
                    wdog       <= 24'd0;
                    line_count <= 10'd0;
                    vsync_late <= 1'b0;
                end
                ST_LAUNCH: if (pulse_cnt != 4'd0) pulse_cnt <= pulse_cnt - 4'd1;
                ST_RUN: begin
                    line_count <= lines_next;
                    wdog       <= wdog + 24'd1;
                    if (rd_vsync && (line_count != 10'd0)) vsync_late <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_img_frame_sequencer.sv
// Directed bench for img_frame_sequencer with HEIGHT=4, RST_PULSE=4, TIMEOUT=50;
// a hand-driven reader model supplies HSYNC pulses, done and abort.
module tb_img_frame_sequencer;
    import img_pkg::*;

    logic       HCLK;
    logic       HRESET;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_value;
    logic       cmd_sign;
    logic       abort;
    logic       rd_hsync;
    logic       rd_vsync;
    logic       rd_done;
    logic       rd_rst_n;
    logic [1:0] cfg_op;
    logic [7:0] cfg_value;
    logic       cfg_sign;
    logic       busy;
    logic       frame_done;
    logic       frame_err;
    logic [1:0] err_code;
    logic [9:0] line_count;

    int n_checks = 0;
    int n_fail   = 0;

    img_frame_sequencer #(
        .HEIGHT     (4),
        .RST_PULSE  (4),
        .TIMEOUT    (24'd50),
        .FIFO_DEPTH (4)
    ) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_value  (cmd_value),
        .cmd_sign   (cmd_sign),
        .abort      (abort),
        .rd_hsync   (rd_hsync),
        .rd_vsync   (rd_vsync),
        .rd_done    (rd_done),
        .rd_rst_n   (rd_rst_n),
        .cfg_op     (cfg_op),
        .cfg_value  (cfg_value),
        .cfg_sign   (cfg_sign),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .err_code   (err_code),
        .line_count (line_count)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench still running at %0t, required completion", $time);
        $fatal(1, "bench timeout");
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic push(input logic [1:0] op, input logic [7:0] v, input logic s);
        cmd_op    = op;
        cmd_value = v;
        cmd_sign  = s;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_run(output int cyc);
        cyc = 0;
        while (rd_rst_n !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (frame_done !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    task automatic drive_lines(input int n);
        for (int i = 0; i < n; i++) begin
            rd_hsync = 1'b1;
            tick();
            rd_hsync = 1'b0;
            tick();
        end
    endtask

    task automatic pulse_done();
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
    endtask

    task automatic test_reset();
        HRESET = 1'b0;
        #1;
        n_checks++;
        if ({rd_rst_n, busy, frame_done, frame_err, err_code} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got rst_n/busy/done/err/code=%b, expected 000000",
                     {rd_rst_n, busy, frame_done, frame_err, err_code});
        end
        n_checks++;
        if ({cfg_op, cfg_value, cfg_sign} !== 11'd0 || line_count !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_cfg: got cfg=%h lines=%0d, expected 0/0",
                     {cfg_op, cfg_value, cfg_sign}, line_count);
        end
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b, expected 1", cmd_ready);
        end
        tick();
        tick();
        HRESET = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int c;
        push(OP_BRIGHT, 8'd100, 1'b1);
        wait_run(c);
        n_checks++;
        if (c !== 6) begin
            n_fail++;
            $display("FAIL single_launch_latency: got %0d cycles after push edge, expected 6", c);
        end
        n_checks++;
        if ({cfg_op, cfg_value, cfg_sign} !== {OP_BRIGHT, 8'd100, 1'b1} || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_cfg_run: got op=%0d val=%0d sign=%b busy=%b, expected 1/100/1 busy 1",
                     cfg_op, cfg_value, cfg_sign, busy);
        end
        drive_lines(4);
        pulse_done();
        wait_done(c);
        n_checks++;
        if (c !== 0 || err_code !== ERR_OK || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL single_status: got wait=%0d code=%0d err=%b, expected 0/0/0", c, err_code, frame_err);
        end
        n_checks++;
        if (line_count !== 10'd4 || rd_rst_n !== 1'b0) begin
            n_fail++;
            $display("FAIL single_report: got lines=%0d rst_n=%b, expected 4/0", line_count, rd_rst_n);
        end
        n_checks++;
        if ({cfg_op, cfg_value, cfg_sign} !== {OP_BRIGHT, 8'd100, 1'b1}) begin
            n_fail++;
            $display("FAIL single_cfg_report: got op=%0d val=%0d sign=%b, expected 1/100/1",
                     cfg_op, cfg_value, cfg_sign);
        end
        tick();
        n_checks++;
        if (frame_done !== 1'b0 || busy !== 1'b0 || line_count !== 10'd4) begin
            n_fail++;
            $display("FAIL single_after: got done=%b busy=%b lines=%0d, expected 0/0/4",
                     frame_done, busy, line_count);
        end
    endtask

    task automatic test_back_to_back();
        int c;
        int frames;
        frames = 0;
        push(OP_THRESH, 8'hAA, 1'b1);
        wait_run(c);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (cmd_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ready_before_%0d: got %b, expected 1", k, cmd_ready);
            end
            push(2'(k), 8'(k + 1), k[0]);
        end
        n_checks++;
        if (cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_ready_full: got %b, expected 0", cmd_ready);
        end
        push(OP_BRIGHT, 8'h55, 1'b1);
        drive_lines(4);
        pulse_done();
        wait_done(c);
        if (frame_done === 1'b1) frames++;
        n_checks++;
        if (err_code !== ERR_OK || {cfg_op, cfg_value, cfg_sign} !== {OP_THRESH, 8'hAA, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b_first: got code=%0d cfg=%0d/%h/%b, expected 0 3/aa/1",
                     err_code, cfg_op, cfg_value, cfg_sign);
        end
        for (int k = 0; k < 4; k++) begin
            wait_run(c);
            n_checks++;
            if (c !== 7) begin
                n_fail++;
                $display("FAIL b2b_latency_%0d: got %0d, expected 7", k, c);
            end
            n_checks++;
            if ({cfg_op, cfg_value, cfg_sign} !== {2'(k), 8'(k + 1), k[0]}) begin
                n_fail++;
                $display("FAIL b2b_cfg_%0d: got %0d/%0d/%b, expected %0d/%0d/%0d",
                         k, cfg_op, cfg_value, cfg_sign, k, k + 1, k[0]);
            end
            if (k == 0) begin
                n_checks++;
                if (cmd_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_ready_after_pop: got %b, expected 1", cmd_ready);
                end
            end
            drive_lines(4);
            pulse_done();
            wait_done(c);
            if (frame_done === 1'b1) frames++;
            n_checks++;
            if (c !== 0 || err_code !== ERR_OK) begin
                n_fail++;
                $display("FAIL b2b_status_%0d: got wait=%0d code=%0d, expected 0/0", k, c, err_code);
            end
        end
        n_checks++;
        if (frames !== 5) begin
            n_fail++;
            $display("FAIL b2b_frame_count: got %0d, expected 5", frames);
        end
        for (int i = 0; i < 10; i++) tick();
        n_checks++;
        if (busy !== 1'b0 || rd_rst_n !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_fifth_ignored: got busy=%b rst_n=%b, expected 0/0", busy, rd_rst_n);
        end
    endtask

    task automatic test_line_mismatch();
        int c;
        push(OP_INVERT, 8'h33, 1'b0);
        wait_run(c);
        drive_lines(3);
        pulse_done();
        wait_done(c);
        n_checks++;
        if (c !== 0 || frame_err !== 1'b1 || err_code !== ERR_LINES || line_count !== 10'd3) begin
            n_fail++;
            $display("FAIL mismatch: got wait=%0d err=%b code=%0d lines=%0d, expected 0/1/1/3",
                     c, frame_err, err_code, line_count);
        end
    endtask

    task automatic test_timeout();
        int c;
        push(OP_THRESH, 8'h80, 1'b0);
        wait_run(c);
        wait_done(c);
        n_checks++;
        if (c !== 50) begin
            n_fail++;
            $display("FAIL timeout_cycles: got %0d cycles from RUN entry, expected 50", c);
        end
        n_checks++;
        if (frame_err !== 1'b1 || err_code !== ERR_TIMEOUT || line_count !== 10'd0) begin
            n_fail++;
            $display("FAIL timeout_status: got err=%b code=%0d lines=%0d, expected 1/2/0",
                     frame_err, err_code, line_count);
        end
        tick();
    endtask

    task automatic test_abort();
        int c;
        push(OP_INVERT, 8'h11, 1'b0);
        push(OP_PASS, 8'h22, 1'b1);
        wait_run(c);
        drive_lines(4);
        abort   = 1'b1;
        rd_done = 1'b1;
        tick();
        abort   = 1'b0;
        rd_done = 1'b0;
        wait_done(c);
        n_checks++;
        if (c !== 0 || frame_err !== 1'b1 || err_code !== ERR_ABORT) begin
            n_fail++;
            $display("FAIL abort_status: got wait=%0d err=%b code=%0d, expected 0/1/3", c, frame_err, err_code);
        end
        abort = 1'b1;
        wait_run(c);
        abort = 1'b0;
        n_checks++;
        if (c !== 7 || {cfg_op, cfg_value, cfg_sign} !== {OP_PASS, 8'h22, 1'b1}) begin
            n_fail++;
            $display("FAIL abort_next_launch: got latency=%0d cfg=%0d/%h/%b, expected 7 0/22/1",
                     c, cfg_op, cfg_value, cfg_sign);
        end
        drive_lines(4);
        pulse_done();
        wait_done(c);
        n_checks++;
        if (c !== 0 || err_code !== ERR_OK || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_next_status: got wait=%0d code=%0d err=%b, expected 0/0/0", c, err_code, frame_err);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        int c;
        push(OP_BRIGHT, 8'h01, 1'b0);
        wait_run(c);
        push(OP_INVERT, 8'h02, 1'b1);
        push(OP_THRESH, 8'h03, 1'b0);
        drive_lines(2);
        #3;
        HRESET = 1'b0;
        #1;
        n_checks++;
        if ({rd_rst_n, busy, frame_done, frame_err, err_code} !== 6'b0 || line_count !== 10'd0) begin
            n_fail++;
            $display("FAIL midreset_ctrl: got rst_n/busy/done/err/code=%b lines=%0d, expected 000000/0",
                     {rd_rst_n, busy, frame_done, frame_err, err_code}, line_count);
        end
        n_checks++;
        if ({cfg_op, cfg_value, cfg_sign} !== 11'd0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_cfg: got cfg=%h ready=%b, expected 000/1",
                     {cfg_op, cfg_value, cfg_sign}, cmd_ready);
        end
        tick();
        tick();
        HRESET = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_checks++;
            if (busy !== 1'b0 || rd_rst_n !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset_idle_%0d: got busy=%b rst_n=%b, expected 0/0", i, busy, rd_rst_n);
            end
        end
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_ready: got %b, expected 1", cmd_ready);
        end
    endtask

    initial begin
        HRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_value = 8'd0;
        cmd_sign  = 1'b0;
        abort     = 1'b0;
        rd_hsync  = 1'b0;
        rd_vsync  = 1'b0;
        rd_done   = 1'b0;
        #2;
        test_reset();
        test_single();
        test_back_to_back();
        test_line_mismatch();
        test_timeout();
        test_abort();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
